fifo_sync_param: RTL and testbench

Parametrised single-clock FIFO. It is the next generation of the unit-level 8-bit FIFO and keeps its port vocabulary (en_w/en_r, data_w/data_r, full/empty). It adds configurable width and depth, programmable almost-full/almost-empty levels, an occupancy count, sticky overflow/underflow error flags, a synchronous flush, and an optional first-word-fall-through (FWFT) read mode. It buffers byte/word streams between producer and consumer stages inside the vout datapath.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_ram.sv | 23 ++
 rtl/fifo_sync_param.sv | 124 ++++++++++++
 tb/tb_fifo_sync_param.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DW storage array: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost levels, sticky error
// flags, synchronous flush and optional first-word-fall-through read port.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DW       = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FIFO_MODE_REG
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          en_w,
  input  logic [DW-1:0]                 data_w,
  input  logic                          en_r,
  output logic [DW-1:0]                 data_r,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [fifo_ptr_w(DEPTH)-1:0]  count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AF_LVL  = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_LVL  = AE_LEVEL[AW:0];

  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW:0]   count_w;
  logic          full_w, empty_w;
  logic          wr_acc, rd_acc;
  logic [DW-1:0] ram_rdata;

  assign count_w = wptr_q - rptr_q;
  assign empty_w = (wptr_q == rptr_q);
  assign full_w  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Acceptance uses start-of-cycle status only: no write-through on full and
  // no read-through on empty, and a flush masks both requests.
  assign wr_acc = en_w & ~full_w  & ~clr;
  assign rd_acc = en_r & ~empty_w & ~clr;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PTR_ONE;
      if (rd_acc) rptr_d = rptr_q + PTR_ONE;
      if (en_w && full_w)  ovf_d = 1'b1;
      if (en_r && empty_w) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  fifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q[AW-1:0]),
    .wdata (data_w),
    .raddr (rptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Registered mode keeps the last word popped, even across a flush;
  // fall-through mode shows the head word directly and zero when empty.
  if (FWFT == FIFO_MODE_REG) begin : g_reg
    logic [DW-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (rd_acc) rdata_d = ram_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
    end

    assign data_r = rdata_q;
  end else begin : g_fwft
    assign data_r = empty_w ? '0 : ram_rdata;
  end

  assign full         = full_w;
  assign empty        = empty_w;
  assign count        = count_w;
  assign almost_full  = (count_w >= AF_LVL);
  assign almost_empty = (count_w <= AE_LVL);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench driving a registered-read and a fall-through FIFO with identical stimulus,
// checked against a queue-based reference model plus a table of fixed vectors.
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n, clr, en_w, en_r;
  logic [DW-1:0] data_w;

  logic [DW-1:0] r_data_r, f_data_r;
  logic          r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0]    r_count, f_count;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mq [$];
  bit            m_ovf, m_unf;
  logic [DW-1:0] m_rd;

  typedef struct {
    bit            w;
    logic [DW-1:0] wd;
    bit            r;
    bit            c;
    int            cnt;
    bit            emp;
    bit            unf;
    logic [DW-1:0] rd_reg;
    logic [DW-1:0] rd_fw;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  fifo_sync_param #(.DW(DW), .DEPTH(DEPTH), .FWFT(0)) dut_reg (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en_w(en_w), .data_w(data_w), .en_r(en_r),
    .data_r(r_data_r), .full(r_full), .empty(r_empty), .almost_full(r_af),
    .almost_empty(r_ae), .count(r_count), .overflow(r_ovf), .underflow(r_unf)
  );

  fifo_sync_param #(.DW(DW), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en_w(en_w), .data_w(data_w), .en_r(en_r),
    .data_r(f_data_r), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rd  = '0;
  endtask

  task automatic model_edge(input bit w, input logic [DW-1:0] wd, input bit r, input bit c);
    bit was_empty, was_full;
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      if (r) begin
        if (was_empty) m_unf = 1'b1;
        else           m_rd  = mq.pop_front();
      end
      if (w) begin
        if (was_full) m_ovf = 1'b1;
        else          mq.push_back(wd);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    int n;
    logic [DW-1:0] head;
    n    = mq.size();
    head = (n > 0) ? mq[0] : '0;
    check({tag, ".count"},   r_count, n);
    check({tag, ".fcount"},  f_count, n);
    check({tag, ".empty"},   r_empty, n == 0);
    check({tag, ".fempty"},  f_empty, n == 0);
    check({tag, ".full"},    r_full, n == DEPTH);
    check({tag, ".ffull"},   f_full, n == DEPTH);
    check({tag, ".afull"},   r_af, n >= DEPTH - 2);
    check({tag, ".fafull"},  f_af, n >= DEPTH - 2);
    check({tag, ".aempty"},  r_ae, n <= 2);
    check({tag, ".faempty"}, f_ae, n <= 2);
    check({tag, ".ovf"},     r_ovf, m_ovf);
    check({tag, ".fovf"},    f_ovf, m_ovf);
    check({tag, ".unf"},     r_unf, m_unf);
    check({tag, ".funf"},    f_unf, m_unf);
    check({tag, ".rdata"},   r_data_r, m_rd);
    check({tag, ".fdata"},   f_data_r, head);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic apply_stimulus(input bit w, input logic [DW-1:0] wd, input bit r, input bit c,
                                input string tag);
    en_w   = w;
    data_w = wd;
    en_r   = r;
    clr    = c;
    @(posedge clk);
    model_edge(w, wd, r, c);
    #1;
    en_w = 1'b0;
    en_r = 1'b0;
    clr  = 1'b0;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en_w = 1'b0; en_r = 1'b0; clr = 1'b0; data_w = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    check_outputs("reset");
  endtask

  initial begin
    vecs[0] = '{w:0, wd:8'h00, r:1, c:0, cnt:0, emp:1, unf:1, rd_reg:8'h00, rd_fw:8'h00};
    vecs[1] = '{w:1, wd:8'h11, r:0, c:0, cnt:1, emp:0, unf:1, rd_reg:8'h00, rd_fw:8'h11};
    vecs[2] = '{w:1, wd:8'h22, r:1, c:0, cnt:1, emp:0, unf:1, rd_reg:8'h11, rd_fw:8'h22};
    vecs[3] = '{w:1, wd:8'h99, r:0, c:1, cnt:0, emp:1, unf:0, rd_reg:8'h11, rd_fw:8'h00};
    vecs[4] = '{w:1, wd:8'h33, r:0, c:0, cnt:1, emp:0, unf:0, rd_reg:8'h11, rd_fw:8'h33};
    vecs[5] = '{w:0, wd:8'h00, r:1, c:0, cnt:0, emp:1, unf:0, rd_reg:8'h33, rd_fw:8'h00};

    do_reset();
    check("rst.count", r_count, 0);
    check("rst.empty", r_empty, 1);
    check("rst.aempty", r_ae, 1);
    check("rst.full", r_full, 0);
    check("rst.afull", r_af, 0);
    check("rst.data_r", r_data_r, 0);

    // Fixed vectors with hand-computed expectations.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].w, vecs[i].wd, vecs[i].r, vecs[i].c, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.count", i), r_count, vecs[i].cnt);
      check($sformatf("vec%0d.empty", i), r_empty, vecs[i].emp);
      check($sformatf("vec%0d.unf", i), r_unf, vecs[i].unf);
      check($sformatf("vec%0d.rd_reg", i), r_data_r, vecs[i].rd_reg);
      check($sformatf("vec%0d.rd_fwft", i), f_data_r, vecs[i].rd_fw);
    end

    // Fill and drain.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1, i[7:0], 0, 0, "fill");
      check("fill.afull", r_af, (i + 1) >= 14);
    end
    check("fill.full", r_full, 1);
    check("fill.count16", r_count, 16);
    apply_stimulus(1, 8'hAA, 0, 0, "ovf");
    check("ovf.flag", r_ovf, 1);
    check("ovf.count", r_count, 16);
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(0, 8'h00, 1, 0, "drain");
      check("drain.data", r_data_r, i);
    end
    check("drain.empty", r_empty, 1);
    apply_stimulus(0, 8'h00, 1, 0, "unf");
    check("unf.flag", r_unf, 1);
    check("unf.hold", r_data_r, 8'h0F);
    apply_stimulus(0, 8'h00, 0, 1, "clrflags");
    check("clr.ovf", r_ovf, 0);
    check("clr.unf", r_unf, 0);

    // Steady-state simultaneous traffic at count 5.
    for (int i = 0; i < 5; i++) apply_stimulus(1, 8'(8'h40 + i), 0, 0, "pre5");
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1, 8'(8'h50 + i), 1, 0, "rw");
      check("rw.count", r_count, 5);
    end

    // Simultaneous requests at the empty and full boundaries.
    apply_stimulus(0, 8'h00, 0, 1, "clr2");
    apply_stimulus(1, 8'hC3, 1, 0, "rw_empty");
    check("rw_empty.count", r_count, 1);
    check("rw_empty.unf", r_unf, 1);
    for (int i = 0; i < DEPTH - 1; i++) apply_stimulus(1, 8'(8'h80 + i), 0, 0, "refill");
    apply_stimulus(1, 8'hEE, 1, 0, "rw_full");
    check("rw_full.count", r_count, 15);
    check("rw_full.ovf", r_ovf, 1);
    check("rw_full.rd", r_data_r, 8'hC3);

    // Fall-through: a write into an empty FIFO is visible before any read.
    apply_stimulus(0, 8'h00, 0, 1, "clr3");
    apply_stimulus(1, 8'h5A, 0, 0, "fwft_w");
    check("fwft.data", f_data_r, 8'h5A);
    check("fwft.empty", f_empty, 0);
    apply_stimulus(0, 8'h00, 1, 0, "fwft_r");
    check("fwft.empty2", f_empty, 1);
    check("fwft.zero", f_data_r, 0);

    // Flush beats a same-cycle write.
    for (int i = 0; i < 7; i++) apply_stimulus(1, 8'(8'h10 + i), 0, 0, "to7");
    apply_stimulus(1, 8'hBB, 0, 1, "clr_w");
    check("clr_w.count", r_count, 0);
    check("clr_w.empty", r_empty, 1);

    // Asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) apply_stimulus(1, 8'(8'h20 + i), 1, 0, "to3");
    apply_stimulus(0, 8'h00, 1, 0, "pop1");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midrst");
    check("midrst.count", r_count, 0);
    check("midrst.data", r_data_r, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("postrst");

    // Randomised traffic with write-heavy then read-heavy phases.
    for (int i = 0; i < 1600; i++) begin
      int wp;
      wp = (i < 800) ? 65 : 35;
      apply_stimulus($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < (100 - wp),
                     $urandom_range(0, 99) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
